// File: rtl/bram_line_writer.sv
`default_nettype none
// ============================================================================
// Module   : bram_line_writer
// Purpose  : Packs an 8-bit pixel stream into 64-bit little-endian words and
//            writes them to consecutive addresses of a BRAM port A, starting at
//            word 0, for a frame of N words.
//            The first pixel of a word lands in dina[7:0].
//            pix_last flushes a partial word with the unfilled bytes zeroed.
// Ports    :
//   clk         rising-edge clock
//   reset_n     synchronous active-low reset
//   start       one-cycle frame-start pulse (honoured only when idle)
//   num_words   words in the frame, sampled on start
//   pix_data    pixel byte
//   pix_valid   pixel valid
//   pix_last    last pixel of a line, qualified by pix_valid
//   pix_ready   pixel accepted when pix_valid & pix_ready
//   ena         BRAM port-A enable
//   wea         BRAM port-A write enable
//   addra       BRAM port-A word address
//   dina        BRAM port-A write data (8 pixels)
//   busy        frame in progress
//   done        one-cycle pulse at frame end
//   word_count  words written in the current or last frame
// Revision : 1.0 - initial release
// ============================================================================
module bram_line_writer #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W:0]   num_words,
  input  logic [7:0]        pix_data,
  input  logic              pix_valid,
  input  logic              pix_last,
  output logic              pix_ready,
  output logic              ena,
  output logic              wea,
  output logic [ADDR_W-1:0] addra,
  output logic [63:0]       dina,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   word_count
);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_FILL  = 2'd1;
  localparam logic [1:0] c_WRITE = 2'd2;
  localparam logic [1:0] c_DONE  = 2'd3;

  // Largest frame the address space can hold: 2^ADDR_W words.
  localparam logic [ADDR_W:0] c_MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};

  logic [1:0]        r_state;
  logic [ADDR_W:0]   r_n;
  logic [ADDR_W-1:0] r_addr;
  logic [2:0]        r_idx;
  logic [63:0]       r_pack;
  logic [ADDR_W:0]   r_word_count;
  logic [ADDR_W-1:0] r_addra;
  logic [63:0]       r_dina;

  logic              w_accept;
  logic              w_word_end;
  logic [63:0]       w_pack_next;
  logic [ADDR_W:0]   w_n_clamped;
  logic [ADDR_W:0]   w_count_inc;

  assign w_accept    = (r_state == c_FILL) && pix_valid;
  assign w_word_end  = (r_idx == 3'd7) || pix_last;
  assign w_n_clamped = (num_words > c_MAX_WORDS) ? c_MAX_WORDS : num_words;
  assign w_count_inc = r_word_count + 1'b1;

  // Pack register with the incoming byte merged at the current byte slot.
  always_comb begin
    w_pack_next = r_pack;
    w_pack_next[{r_idx, 3'b000} +: 8] = pix_data;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state      <= c_IDLE;
      r_n          <= '0;
      r_addr       <= '0;
      r_idx        <= '0;
      r_pack       <= '0;
      r_word_count <= '0;
      r_addra      <= '0;
      r_dina       <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (start) begin
            r_addr       <= '0;
            r_idx        <= '0;
            r_pack       <= '0;
            r_word_count <= '0;
            r_n          <= w_n_clamped;
            r_state      <= (num_words == '0) ? c_DONE : c_FILL;
          end
        end

        c_FILL: begin
          if (w_accept) begin
            r_pack <= w_pack_next;
            if (w_word_end) begin
              // Capture the completed word now so it is on dina during the
              // single WRITE cycle that follows.
              r_dina  <= w_pack_next;
              r_addra <= r_addr;
              r_idx   <= '0;
              r_state <= c_WRITE;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end

        c_WRITE: begin
          r_addr       <= r_addr + 1'b1;
          r_word_count <= w_count_inc;
          r_pack       <= '0;
          r_state      <= (w_count_inc == r_n) ? c_DONE : c_FILL;
        end

        default: begin
          r_state <= c_IDLE;
        end
      endcase
    end
  end

  // Control outputs are pure state decodes; data/address are registers that
  // keep their last written value outside WRITE.
  assign pix_ready  = (r_state == c_FILL);
  assign ena        = (r_state == c_WRITE);
  assign wea        = (r_state == c_WRITE);
  assign busy       = (r_state == c_FILL) || (r_state == c_WRITE);
  assign done       = (r_state == c_DONE);
  assign addra      = r_addra;
  assign dina       = r_dina;
  assign word_count = r_word_count;

endmodule
`default_nettype wire
